// File: rtl/lfsr_serial_collector.sv
// Serial-to-parallel collector for the LFSR generator's OUT/Valid stream.
// Reassembles LSB-first frames of WIDTH bits and queues completed bytes in a
// show-ahead FIFO. Reports aborted frames (one-cycle pulse) and dropped bytes
// (sticky until reset).
module lfsr_serial_collector #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     serial_in,
  input  logic                     serial_valid,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int unsigned BcW  = $clog2(WIDTH);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [BcW-1:0]  BitLast = BcW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // Frame assembly state
  logic [BcW-1:0]   r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_frame_err;

  // FIFO state
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             r_overflow;

  logic [WIDTH-1:0] w_frame;
  logic             w_last_bit;
  logic             w_push;
  logic             w_abort;
  logic             w_pop;
  logic             w_full;
  logic             w_wr_en;
  logic             w_drop;

  // Decode frame completion/abort and the FIFO push/pop handshake.
  always_comb begin
    // The completed byte must include the bit arriving on this edge.
    w_frame             = r_shift;
    w_frame[r_bit_cnt]  = serial_in;
    w_last_bit          = (r_bit_cnt == BitLast);
    w_push              = serial_valid && w_last_bit;
    w_abort             = !serial_valid && (r_bit_cnt != '0);
    w_pop               = rd_en && (r_count != '0);
    w_full              = (r_count == CntFull);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    w_wr_en             = w_push && (!w_full || w_pop);
    w_drop              = w_push && w_full && !w_pop;
  end

  // Shift register, bit counter and abort pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      if (serial_valid) begin
        r_shift   <= w_frame;
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
      end else begin
        // Partial frame bits are simply overwritten by the next frame.
        r_bit_cnt <= '0;
      end
    end
  end

  // Circular buffer storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mem      <= '{default: '0};
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_frame;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Show-ahead read and status outputs.
  always_comb begin
    data_out   = r_mem[r_rd_ptr];
    data_valid = (r_count != '0);
    full       = w_full;
    count      = r_count;
    frame_err  = r_frame_err;
    overflow   = r_overflow;
  end

endmodule

// File: tb/tb_lfsr_serial_collector.sv
// Bench for lfsr_serial_collector: table-driven frame/pop vectors, hand-written
// corner sequences and a randomized run checked against a queue-based model.
module tb_lfsr_serial_collector;

  localparam int W = 8;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       serial_valid;
  logic       rd_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic [2:0] count;
  logic       frame_err;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  lfsr_serial_collector #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .count        (count),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of bytes plus the number of bits collected so far.
  logic [7:0] m_q[$];
  int         m_bits = 0;
  logic [7:0] m_acc  = '0;
  bit         m_ferr = 0;
  bit         m_ovf  = 0;

  task automatic model_step(input bit rst, input bit sv, input bit si, input bit rd);
    bit         pop;
    bit         push;
    bit         was_full;
    logic [7:0] pb;
    if (!rst) begin
      m_q.delete();
      m_bits = 0;
      m_ferr = 0;
      m_ovf  = 0;
      return;
    end
    push = 0;
    pb   = '0;
    m_ferr = 0;
    if (sv) begin
      m_acc[m_bits] = si;
      m_bits++;
      if (m_bits == W) begin
        push   = 1;
        pb     = m_acc;
        m_bits = 0;
      end
    end else if (m_bits != 0) begin
      m_bits = 0;
      m_ferr = 1;
    end
    was_full = (m_q.size() == D);
    pop      = rd && (m_q.size() != 0);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (was_full && !pop) m_ovf = 1;
      else m_q.push_back(pb);
    end
  endtask

  task automatic tick(input bit rst, input bit sv, input bit si, input bit rd);
    reset        = rst;
    serial_valid = sv;
    serial_in    = si;
    rd_en        = rd;
    @(posedge clock);
    model_step(rst, sv, si, rd);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rd_last);
    for (int i = 0; i < W; i++) tick(1, 1, b[i], (i == W - 1) ? rd_last : 1'b0);
  endtask

  task automatic pop_one();
    tick(1, 0, 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".data_out"},   32'(data_out),   32'h0);
    chk({tag, ".data_valid"}, 32'(data_valid), 32'h0);
    chk({tag, ".full"},       32'(full),       32'h0);
    chk({tag, ".count"},      32'(count),      32'h0);
    chk({tag, ".frame_err"},  32'(frame_err),  32'h0);
    chk({tag, ".overflow"},   32'(overflow),   32'h0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"},      32'(count),      32'(m_q.size()));
    chk({tag, ".data_valid"}, 32'(data_valid), 32'(m_q.size() != 0));
    chk({tag, ".full"},       32'(full),       32'(m_q.size() == D));
    chk({tag, ".frame_err"},  32'(frame_err),  32'(m_ferr));
    chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
    if (m_q.size() != 0) chk({tag, ".data_out"}, 32'(data_out), 32'(m_q[0]));
  endtask

  typedef struct {
    bit         is_pop;
    logic [7:0] val;
    bit         rd_last;
    int         exp_cnt;
    bit         exp_full;
    bit         exp_ovf;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Frame/pop table: back-to-back fill with pointer wrap, overflow, drain.
    vecs.push_back('{0, 8'h01, 0, 1, 0, 0, 8'h01});
    vecs.push_back('{0, 8'h80, 0, 2, 0, 0, 8'h01});
    vecs.push_back('{0, 8'hFF, 0, 3, 0, 0, 8'h01});
    vecs.push_back('{0, 8'h5A, 0, 4, 1, 0, 8'h01});
    vecs.push_back('{0, 8'hC3, 0, 4, 1, 1, 8'h01});
    vecs.push_back('{1, 8'h00, 0, 3, 0, 1, 8'h80});
    vecs.push_back('{1, 8'h00, 0, 2, 0, 1, 8'hFF});
    vecs.push_back('{1, 8'h00, 0, 1, 0, 1, 8'h5A});
    vecs.push_back('{1, 8'h00, 0, 0, 0, 1, 8'h00});

    // Reset state
    tick(0, 0, 0, 0);
    tick(0, 1, 1, 1);
    chk_all_zero("reset");

    // Single frame B2 with latency check, then pop
    begin
      logic [7:0] b;
      b = 8'hB2;
      for (int i = 0; i < W - 1; i++) tick(1, 1, b[i], 0);
      chk("single.pre_valid", 32'(data_valid), 32'h0);
      tick(1, 1, b[W-1], 0);
      chk("single.data_out", 32'(data_out),   32'hB2);
      chk("single.valid",    32'(data_valid), 32'h1);
      chk("single.count",    32'(count),      32'h1);
      pop_one();
      chk("single.pop_valid", 32'(data_valid), 32'h0);
      chk("single.pop_count", 32'(count),      32'h0);
    end

    // Table-driven vectors
    for (int v = 0; v < vecs.size(); v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      if (vecs[v].is_pop) pop_one();
      else send_byte(vecs[v].val, vecs[v].rd_last);
      chk({tag, ".count"},    32'(count),      32'(vecs[v].exp_cnt));
      chk({tag, ".valid"},    32'(data_valid), 32'(vecs[v].exp_cnt != 0));
      chk({tag, ".full"},     32'(full),       32'(vecs[v].exp_full));
      chk({tag, ".overflow"}, 32'(overflow),   32'(vecs[v].exp_ovf));
      if (vecs[v].exp_cnt != 0) chk({tag, ".head"}, 32'(data_out), 32'(vecs[v].exp_head));
    end

    // Full FIFO with pop on the completing edge: no overflow, count held
    tick(0, 0, 0, 0);
    chk_all_zero("reset2");
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 1);
    chk("fullpop.count",    32'(count),    32'h4);
    chk("fullpop.full",     32'(full),     32'h1);
    chk("fullpop.overflow", 32'(overflow), 32'h0);
    chk("fullpop.head",     32'(data_out), 32'h22);
    begin
      logic [7:0] exp_order [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("fullpop.order%0d", i), 32'(data_out), 32'(exp_order[i]));
        pop_one();
      end
    end
    chk("fullpop.empty", 32'(count), 32'h0);

    // Aborted frame after 3 bits, then a clean frame
    tick(1, 1, 1, 0);
    tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    chk("abort.no_err_yet", 32'(frame_err), 32'h0);
    tick(1, 0, 0, 0);
    chk("abort.err",   32'(frame_err), 32'h1);
    chk("abort.count", 32'(count),     32'h0);
    tick(1, 0, 0, 0);
    chk("abort.err_clear", 32'(frame_err), 32'h0);
    send_byte(8'h3C, 0);
    chk("abort.next_head",  32'(data_out),  32'h3C);
    chk("abort.next_count", 32'(count),     32'h1);
    chk("abort.next_err",   32'(frame_err), 32'h0);
    pop_one();

    // Reset mid-frame with 2 entries buffered
    send_byte(8'h9D, 0);
    send_byte(8'h46, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 1'(i & 1), 0);
    chk("midrst.count_before", 32'(count), 32'h2);
    tick(0, 1, 1, 1);
    chk_all_zero("midrst");
    send_byte(8'hA7, 0);
    chk("midrst.count", 32'(count),    32'h1);
    chk("midrst.head",  32'(data_out), 32'hA7);

    // Push and pop on the same edge while empty: push lands
    pop_one();
    send_byte(8'h69, 1);
    chk("emptypush.count", 32'(count),    32'h1);
    chk("emptypush.head",  32'(data_out), 32'h69);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      bit rst;
      bit sv;
      bit rd;
      rst = ($urandom_range(0, 499) != 0);
      sv  = ($urandom_range(0, 15) != 0);
      rd  = (i < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      tick(rst, sv, 1'($urandom_range(0, 1)), rd);
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
